// File: rtl/turn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : turn_sequencer_if
// Request, board-access and status bundle between a game controller and
// turn_sequencer.
// Rev     : 1.0
// ============================================================================
interface turn_sequencer_if #(
    parameter int SCORE_W = 4
);
    logic               place_req;
    logic               new_game;
    logic [2:0]         cursor_row;
    logic [2:0]         cursor_col;
    logic [1:0]         cell_state;
    logic               win_detect;

    logic               wr_en;
    logic [2:0]         wr_row;
    logic [2:0]         wr_col;
    logic [1:0]         wr_val;
    logic               board_clr;

    logic [1:0]         cur_player;
    logic [1:0]         winner;
    logic               game_over;
    logic               reject;
    logic               timeout;
    logic [4:0]         move_count;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;

    modport master (
        output place_req, new_game, cursor_row, cursor_col, cell_state, win_detect,
        input  wr_en, wr_row, wr_col, wr_val, board_clr,
        input  cur_player, winner, game_over, reject, timeout, move_count,
        input  score_p1, score_p2
    );

    modport slave (
        input  place_req, new_game, cursor_row, cursor_col, cell_state, win_detect,
        output wr_en, wr_row, wr_col, wr_val, board_clr,
        output cur_player, winner, game_over, reject, timeout, move_count,
        output score_p1, score_p2
    );
endinterface
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : turn_sequencer
// Turn/move FSM for a 5x5 two-player board game with scores. Optional turn
// timer enabled by macro TURN_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module turn_sequencer #(
    parameter int SCORE_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    turn_sequencer_if.slave seq_io
);
    localparam logic [2:0] S_CLEAR     = 3'd0;
    localparam logic [2:0] S_WAIT_MOVE = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [1:0] PLAYER1   = 2'b01;
    localparam logic [1:0] PLAYER2   = 2'b10;
    localparam logic [4:0] ALL_CELLS = 5'd25;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
        $error("turn_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == PLAYER1) ? PLAYER2 : PLAYER1;
    endfunction

    logic [2:0]         state_q,  state_d;
    logic [1:0]         cur_q,    cur_d;
    logic [1:0]         start_q,  start_d;
    logic [2:0]         row_q,    row_d;
    logic [2:0]         col_q,    col_d;
    logic [4:0]         count_q,  count_d;
    logic [1:0]         winner_q, winner_d;
    logic               over_q,   over_d;
    logic               reject_q, reject_d;
    logic [SCORE_W-1:0] p1_q,     p1_d;
    logic [SCORE_W-1:0] p2_q,     p2_d;
    logic               w_move_ok;

`ifdef TURN_TIMEOUT_EN
    localparam int            TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
`endif

    assign w_move_ok = (seq_io.cursor_row <= 3'd4) && (seq_io.cursor_col <= 3'd4)
                       && (seq_io.cell_state == 2'b00);

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        start_d  = start_q;
        row_d    = row_q;
        col_d    = col_q;
        count_d  = count_q;
        winner_d = winner_q;
        over_d   = over_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        reject_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
        // Holding zero outside WAIT_MOVE gives a fresh count on every entry.
        tcnt_d    = '0;
        timeout_d = 1'b0;
`endif
        if (seq_io.new_game) begin
            state_d  = S_CLEAR;
            start_d  = other_player(start_q);
            cur_d    = other_player(start_q);
            count_d  = '0;
            winner_d = 2'b00;
            over_d   = 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    count_d  = '0;
                    winner_d = 2'b00;
                    over_d   = 1'b0;
                    state_d  = S_WAIT_MOVE;
                end
                S_WAIT_MOVE: begin
                    if (seq_io.place_req && w_move_ok) begin
                        row_d   = seq_io.cursor_row;
                        col_d   = seq_io.cursor_col;
                        state_d = S_WRITE;
                    end else begin
                        reject_d = seq_io.place_req;
`ifdef TURN_TIMEOUT_EN
                        if (tcnt_q == TLAST) begin
                            timeout_d = 1'b1;
                            cur_d     = other_player(cur_q);
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
`endif
                    end
                end
                S_WRITE: begin
                    count_d = count_q + 5'd1;
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (seq_io.win_detect) begin
                        winner_d = cur_q;
                        over_d   = 1'b1;
                        state_d  = S_DONE;
                        if (cur_q == PLAYER1) begin
                            p1_d = (&p1_q) ? p1_q : p1_q + 1'b1;
                        end else begin
                            p2_d = (&p2_q) ? p2_q : p2_q + 1'b1;
                        end
                    end else if (count_q == ALL_CELLS) begin
                        winner_d = 2'b00;
                        over_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cur_d   = other_player(cur_q);
                        state_d = S_WAIT_MOVE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_CLEAR;
            cur_q    <= PLAYER1;
            start_q  <= PLAYER1;
            row_q    <= '0;
            col_q    <= '0;
            count_q  <= '0;
            winner_q <= 2'b00;
            over_q   <= 1'b0;
            reject_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            start_q  <= start_d;
            row_q    <= row_d;
            col_q    <= col_d;
            count_q  <= count_d;
            winner_q <= winner_d;
            over_q   <= over_d;
            reject_q <= reject_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign seq_io.timeout = timeout_q;
`else
    assign seq_io.timeout = 1'b0;
`endif

    // Strobes decode from state alone, so wr_en and board_clr are exclusive.
    assign seq_io.wr_en      = (state_q == S_WRITE);
    assign seq_io.board_clr  = (state_q == S_CLEAR);
    assign seq_io.wr_row     = row_q;
    assign seq_io.wr_col     = col_q;
    assign seq_io.wr_val     = cur_q;
    assign seq_io.cur_player = cur_q;
    assign seq_io.winner     = winner_q;
    assign seq_io.game_over  = over_q;
    assign seq_io.reject     = reject_q;
    assign seq_io.move_count = count_q;
    assign seq_io.score_p1   = p1_q;
    assign seq_io.score_p2   = p2_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// Randomized game play for turn_sequencer checked against a move-level game model
// (board array, player turn, scores) kept in the bench.
module tb_turn_sequencer;
    localparam int SW = 2;
    localparam int TO = 8;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    turn_sequencer_if #(.SCORE_W(SW)) seq_if ();

    turn_sequencer #(.SCORE_W(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_io (seq_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] board [5][5];
    logic [1:0] m_cur, m_start, m_winner;
    int         m_cnt, m_sp1, m_sp2;
    bit         m_over;
`ifdef TURN_TIMEOUT_EN
    int         m_wcnt;
`endif

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] flip(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < (1 << SW) - 1) ? v + 1 : v;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                board[r][c] = 2'b00;
    endtask

    // One clock; in_wait marks a cycle the game spends waiting for a move.
    task automatic step(input bit in_wait, input bit accepted);
        bit to_now;
        to_now = 1'b0;
`ifdef TURN_TIMEOUT_EN
        if (in_wait && !accepted) begin
            if (m_wcnt == TO - 1) begin
                to_now = 1'b1;
                m_cur  = flip(m_cur);
                m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end else begin
            m_wcnt = 0;
        end
`endif
        @(posedge clk);
        #1;
        chk_eq("timeout", seq_if.timeout, to_now);
    endtask

    task automatic check_status(input string tag);
        chk_eq({tag, "_player"}, seq_if.cur_player, m_cur);
        chk_eq({tag, "_over"}, seq_if.game_over, m_over);
        chk_eq({tag, "_winner"}, seq_if.winner, m_winner);
        chk_eq({tag, "_count"}, seq_if.move_count, m_cnt);
        chk_eq({tag, "_p1"}, seq_if.score_p1, m_sp1);
        chk_eq({tag, "_p2"}, seq_if.score_p2, m_sp2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seq_if.new_game  = 1'b1;
        seq_if.place_req = 1'b1;
        m_cur = P1; m_start = P1; m_winner = 2'b00;
        m_cnt = 0; m_sp1 = 0; m_sp2 = 0; m_over = 1'b0;
        clear_board();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        seq_if.new_game  = 1'b0;
        seq_if.place_req = 1'b0;
        chk_eq("rst_board_clr", seq_if.board_clr, 1'b1);
        chk_eq("rst_wr_en", seq_if.wr_en, 1'b0);
        chk_eq("rst_reject", seq_if.reject, 1'b0);
        check_status("rst");
        step(1'b0, 1'b0);
        chk_eq("rst_clr_once", seq_if.board_clr, 1'b0);
    endtask

    task automatic new_game(input bit with_place);
        seq_if.new_game = 1'b1;
        if (with_place) begin
            seq_if.place_req  = 1'b1;
            seq_if.cursor_row = 3'd1;
            seq_if.cursor_col = 3'd1;
            seq_if.cell_state = 2'b00;
        end
        m_start = flip(m_start);
        m_cur = m_start; m_cnt = 0; m_over = 1'b0; m_winner = 2'b00;
        clear_board();
        step(1'b0, 1'b0);
        seq_if.new_game  = 1'b0;
        seq_if.place_req = 1'b0;
        chk_eq("ng_board_clr", seq_if.board_clr, 1'b1);
        chk_eq("ng_wr_en", seq_if.wr_en, 1'b0);
        check_status("ng");
        step(1'b0, 1'b0);
        chk_eq("ng_clr_once", seq_if.board_clr, 1'b0);
        chk_eq("ng_no_write", seq_if.wr_en, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(!m_over, 1'b0);
            chk_eq("idle_player", seq_if.cur_player, m_cur);
            chk_eq("idle_no_write", seq_if.wr_en, 1'b0);
        end
    endtask

    task automatic try_move(input int r, input int c, input bit win);
        bit in_range, valid;
        in_range = (r <= 4) && (c <= 4);
        valid    = in_range ? (board[r][c] == 2'b00) : 1'b0;
        seq_if.place_req  = 1'b1;
        seq_if.cursor_row = 3'(r);
        seq_if.cursor_col = 3'(c);
        seq_if.cell_state = in_range ? board[r][c] : 2'($urandom_range(0, 3));
        seq_if.win_detect = win;
        if (m_over) begin
            step(1'b0, 1'b0);
            seq_if.place_req  = 1'b0;
            seq_if.win_detect = 1'b0;
            chk_eq("done_no_reject", seq_if.reject, 1'b0);
            chk_eq("done_no_write", seq_if.wr_en, 1'b0);
            check_status("done");
            return;
        end
        step(1'b1, valid);
        seq_if.place_req = 1'b0;
        if (!valid) begin
            seq_if.win_detect = 1'b0;
            chk_eq("reject", seq_if.reject, 1'b1);
            chk_eq("rej_no_write", seq_if.wr_en, 1'b0);
            chk_eq("rej_player", seq_if.cur_player, m_cur);
            step(1'b1, 1'b0);
            chk_eq("reject_pulse", seq_if.reject, 1'b0);
            chk_eq("rej_count", seq_if.move_count, m_cnt);
            return;
        end
        chk_eq("wr_en", seq_if.wr_en, 1'b1);
        chk_eq("wr_row", seq_if.wr_row, r);
        chk_eq("wr_col", seq_if.wr_col, c);
        chk_eq("wr_val", seq_if.wr_val, m_cur);
        chk_eq("wr_no_clr", seq_if.board_clr, 1'b0);
        board[r][c] = m_cur;
        m_cnt++;
        // A request while the move is in flight must be dropped silently.
        seq_if.place_req  = 1'($urandom_range(0, 1));
        seq_if.cursor_row = 3'd7;
        step(1'b0, 1'b0);
        seq_if.place_req = 1'b0;
        chk_eq("wr_once", seq_if.wr_en, 1'b0);
        chk_eq("busy_no_reject", seq_if.reject, 1'b0);
        chk_eq("move_count", seq_if.move_count, m_cnt);
        step(1'b0, 1'b0);
        seq_if.win_detect = 1'b0;
        if (win) begin
            m_winner = m_cur;
            m_over   = 1'b1;
            if (m_cur == P1) m_sp1 = sat_inc(m_sp1);
            else             m_sp2 = sat_inc(m_sp2);
        end else if (m_cnt == 25) begin
            m_winner = 2'b00;
            m_over   = 1'b1;
        end else begin
            m_cur = flip(m_cur);
        end
        chk_eq("post_reject", seq_if.reject, 1'b0);
        check_status("move");
    endtask

    // mode 0: never win (draw), 1: random wins, 2: P1 wins as soon as possible
    task automatic play_game(input int mode);
        int r, c, guard;
        bit win;
        guard = 0;
        while (!m_over && guard < 200) begin
            guard++;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 7);
                c = $urandom_range(0, 7);
            end else begin
                do begin
                    r = $urandom_range(0, 4);
                    c = $urandom_range(0, 4);
                end while (board[r][c] != 2'b00);
            end
            case (mode)
                1:       win = (m_cnt >= 4) && ($urandom_range(0, 5) == 0);
                2:       win = (m_cur == P1) && (m_cnt >= 4);
                default: win = 1'b0;
            endcase
            try_move(r, c, win);
        end
        chk_eq("game_finished", seq_if.game_over, 1'b1);
    endtask

    // Discard a winning move by starting a new game during WRITE or CHECK.
    task automatic abort_move(input bit in_check);
        seq_if.place_req  = 1'b1;
        seq_if.cursor_row = 3'd2;
        seq_if.cursor_col = 3'd2;
        seq_if.cell_state = 2'b00;
        seq_if.win_detect = 1'b1;
        step(1'b1, 1'b1);
        seq_if.place_req = 1'b0;
        chk_eq("abort_wr_en", seq_if.wr_en, 1'b1);
        if (in_check) begin
            step(1'b0, 1'b0);
            chk_eq("abort_in_check", seq_if.wr_en, 1'b0);
        end
        new_game(1'b0);
        seq_if.win_detect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        seq_if.place_req  = 1'b0;
        seq_if.new_game   = 1'b0;
        seq_if.cursor_row = '0;
        seq_if.cursor_col = '0;
        seq_if.cell_state = 2'b00;
        seq_if.win_detect = 1'b0;
        do_reset();
        idle(10);
        try_move(0, 0, 1'b0);
        try_move(5, 2, 1'b0);
        try_move(0, 0, 1'b0);
        new_game(1'b1);
        play_game(0);
        chk_eq("draw_winner", seq_if.winner, 2'b00);
        try_move(1, 1, 1'b0);
        idle(3);
        for (int g = 0; g < 4; g++) begin
            new_game(1'b0);
            play_game(2);
        end
        chk_eq("p1_saturated", seq_if.score_p1, 3);
        new_game(1'b1);
        abort_move(1'b0);
        abort_move(1'b1);
        for (int g = 0; g < 5; g++) begin
            play_game(1);
            new_game($urandom_range(0, 1) == 1);
        end
        try_move(3, 3, 1'b0);
        try_move(4, 4, 1'b0);
        do_reset();
        try_move(2, 3, 1'b1);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
